reset_sequencer: RTL

//  Board-level reset controller between the PLL, the reset push-button and the SoC.

---
 rtl/reset_seq_pkg.sv | 22 ++
 rtl/rst_sync_filter.sv | 69 ++++++
 rtl/reset_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types for the board reset sequencer: FSM states, reset-cause codes
// and a small constant helper used to size the shared down-counter.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        STAGGER   = 2'd2,
        RUN       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        POR       = 2'd0,
        LOCK_LOSS = 2'd1,
        BUTTON    = 2'd2
    } cause_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync_filter.sv
// Input conditioner: SYNC_STAGES-deep synchroniser followed by a debounce
// filter. With BYPASS_DEBOUNCE set the synchronised level is passed straight
// out (used for PLL lock, which must react without added delay).
module rst_sync_filter #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit BYPASS_DEBOUNCE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic filt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    generate
        if (BYPASS_DEBOUNCE) begin : g_bypass
            assign filt_o = sync_s;
        end else begin : g_debounce
            localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

            logic [DB_W-1:0] db_cnt_q, db_cnt_d;
            logic            stable_q, stable_d;

            // Count consecutive mismatching cycles; adopt the new level only
            // after DEBOUNCE_CYCLES of continuous disagreement.
            always_comb begin
                stable_d = stable_q;
                db_cnt_d = db_cnt_q;
                if (sync_s == stable_q) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    stable_d = sync_s;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end

            // Debounce state registers.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stable_q <= 1'b0;
                    db_cnt_q <= '0;
                end else begin
                    stable_q <= stable_d;
                    db_cnt_q <= db_cnt_d;
                end
            end

            assign filt_o = stable_q;
        end
    endgenerate

endmodule

// File: rtl/reset_sequencer.sv
// Board-level reset controller: waits for PLL lock, holds both resets for
// HOLD_CYCLES, releases peripherals, then the CPU STAGGER_CYCLES later.
// Lock loss or a debounced button press restarts the sequence, dropping both
// resets on the same edge.
// Optional feature macro: RESET_CAUSE_EN adds the cause_out port reporting
// the last reset cause (0=POR, 1=LOCK_LOSS, 2=BUTTON).
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 8
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       locked_in,
    input  logic       button_in,
    output logic       periph_reset_out,
    output logic       cpu_reset_out,
    output logic       ready_out
`ifdef RESET_CAUSE_EN
    ,
    output logic [1:0] cause_out
`endif
);

    localparam int               CNT_W        = $clog2(max_int(HOLD_CYCLES, STAGGER_CYCLES) + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);

    logic locked_s;
    logic btn_stable;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             periph_q, cpu_q, ready_q;

    rst_sync_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BYPASS_DEBOUNCE(1'b1)
    ) u_lock_sync (
        .clk_i  (clk_in),
        .rst_ni (reset_in),
        .async_i(locked_in),
        .filt_o (locked_s)
    );

    rst_sync_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .BYPASS_DEBOUNCE(1'b0)
    ) u_button_filter (
        .clk_i  (clk_in),
        .rst_ni (reset_in),
        .async_i(button_in),
        .filt_o (btn_stable)
    );

    // Next-state logic: lock loss beats button, button beats normal sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!locked_s) begin
            state_d = WAIT_LOCK;
        end else if (btn_stable) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = STAGGER;
                        cnt_d   = STAGGER_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                STAGGER: begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                RUN:     state_d = RUN;
                default: state_d = WAIT_LOCK;
            endcase
        end
    end

    // State, counter and outputs decoded from next state so they move together.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            cpu_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= (state_d == STAGGER) || (state_d == RUN);
            cpu_q    <= (state_d == RUN);
            ready_q  <= (state_d == RUN);
        end
    end

    assign periph_reset_out = periph_q;
    assign cpu_reset_out    = cpu_q;
    assign ready_out        = ready_q;

`ifdef RESET_CAUSE_EN
    cause_t cause_q, cause_d;

    // Record why the sequence restarted; only fresh entries update the cause.
    always_comb begin
        cause_d = cause_q;
        if (!locked_s && (state_q != WAIT_LOCK)) begin
            cause_d = LOCK_LOSS;
        end else if (locked_s && btn_stable && (state_q != HOLD)) begin
            cause_d = BUTTON;
        end
    end

    // Sticky cause register; POR only after reset_in.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            cause_q <= POR;
        end else begin
            cause_q <= cause_d;
        end
    end

    assign cause_out = cause_q;
`endif

endmodule
